// File: rtl/cache_arbiter_types.sv
// ---------------------------------------------------------------------------
// cache_arbiter_types
//   Shared types and constants for the L1-I / L1-D downstream arbiter.
//
//   arb_state_t : arbiter FSM state (idle, I side owns port, D side owns port)
//   REQ_I/REQ_D : bit positions of the I and D sides in request/grant vectors
//   grant_of()  : one-hot owner vector {d,i} for a given arbiter state
// ---------------------------------------------------------------------------
package cache_arbiter_types;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    // Owner vector seen by the outside world; idle (or any unused encoding)
    // reports no owner.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            ARB_I:   g[REQ_I] = 1'b1;
            ARB_D:   g[REQ_D] = 1'b1;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin picker.
//
//   req  [1:0] in  : pending requests, bit REQ_I / REQ_D
//   last       in  : side served most recently (REQ_I or REQ_D encoding)
//   pick [1:0] out : one-hot winner, 00 when nothing is pending
//
//   A lone requester always wins. On a tie the side that was not served
//   last wins, which gives strict alternation under continuous load.
// ---------------------------------------------------------------------------
module rr_pick2
    import cache_arbiter_types::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req[REQ_I] && req[REQ_D]) begin
            pick = 2'b00;
            if (last == 1'(REQ_D)) begin
                pick[REQ_I] = 1'b1;
            end else begin
                pick[REQ_D] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//   Shares one downstream memory port between the L1 instruction cache
//   (I side) and the L1 data cache (D side). One side owns the port at a
//   time; its read/write, address and write line are forwarded and the
//   downstream completion is routed back to the owner only. Ties are broken
//   round robin.
//
//   Parameters
//     s_line  : line width in bits
//     s_addr  : address width in bits
//     d_first : side that wins the first tie after reset (1 = D, 0 = I)
//
//   Ports
//     clk, rst_n                       : clock, asynchronous active-low reset
//     i_read/i_write/i_address/i_wdata : I-side request, held until i_resp
//     i_resp, i_rdata                  : I-side completion pulse and read line
//     d_read/d_write/d_address/d_wdata : D-side request, held until d_resp
//     d_resp, d_rdata                  : D-side completion pulse and read line
//     downstream_read/write/address/wdata : forwarded request of the owner
//     downstream_resp, downstream_rdata   : downstream completion and line
//     grant [1:0]                      : one-hot owner {d,i}, 00 when idle
// ---------------------------------------------------------------------------
module cache_arbiter
    import cache_arbiter_types::*;
#(
    parameter int s_line  = 256,
    parameter int s_addr  = 32,
    parameter bit d_first = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [s_addr-1:0] i_address,
    input  logic [s_line-1:0] i_wdata,
    output logic              i_resp,
    output logic [s_line-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic              d_resp,
    output logic [s_line-1:0] d_rdata,

    output logic              downstream_read,
    output logic              downstream_write,
    output logic [s_addr-1:0] downstream_address,
    output logic [s_line-1:0] downstream_wdata,
    input  logic              downstream_resp,
    input  logic [s_line-1:0] downstream_rdata,

    output logic [1:0]        grant
);

    // Seeding "last served" with the opposite side makes d_first win the
    // very first tie.
    localparam logic LAST_INIT = d_first ? 1'(REQ_I) : 1'(REQ_D);

    arb_state_t state_reg;
    logic       last_reg;

    logic [1:0] req;
    logic [1:0] pick;

    assign req[REQ_I] = i_read | i_write;
    assign req[REQ_D] = d_read | d_write;

    rr_pick2 u_pick (
        .req  (req),
        .last (last_reg),
        .pick (pick)
    );

    // -----------------------------------------------------------------------
    // Ownership FSM. In the completion cycle the served side's request is
    // still legally asserted, so only the other side is considered for a
    // direct hand-over; otherwise we pass through idle. This avoids serving
    // the same request twice and gives zero-bubble alternation.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
            last_reg  <= LAST_INIT;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick[REQ_I]) begin
                        state_reg <= ARB_I;
                    end else if (pick[REQ_D]) begin
                        state_reg <= ARB_D;
                    end
                end
                ARB_I: begin
                    if (downstream_resp) begin
                        last_reg  <= 1'(REQ_I);
                        state_reg <= req[REQ_D] ? ARB_D : ARB_IDLE;
                    end
                end
                ARB_D: begin
                    if (downstream_resp) begin
                        last_reg  <= 1'(REQ_D);
                        state_reg <= req[REQ_I] ? ARB_I : ARB_IDLE;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output steering: purely a function of the current owner, so reset
    // clears every forwarded signal immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        downstream_read    = 1'b0;
        downstream_write   = 1'b0;
        downstream_address = '0;
        downstream_wdata   = '0;
        i_resp             = 1'b0;
        d_resp             = 1'b0;
        case (state_reg)
            ARB_I: begin
                downstream_read    = i_read;
                downstream_write   = i_write;
                downstream_address = i_address;
                downstream_wdata   = i_wdata;
                i_resp             = downstream_resp;
            end
            ARB_D: begin
                downstream_read    = d_read;
                downstream_write   = d_write;
                downstream_address = d_address;
                downstream_wdata   = d_wdata;
                d_resp             = downstream_resp;
            end
            default: begin
                downstream_read    = 1'b0;
                downstream_write   = 1'b0;
            end
        endcase
    end

    // Read data is broadcast; the per-side resp pulse qualifies it.
    assign i_rdata = downstream_rdata;
    assign d_rdata = downstream_rdata;
    assign grant   = grant_of(state_reg);

endmodule
